// File: rtl/mips_mc_control.sv
// mips_mc_control -- main control unit of the multicycle MIPS core.
//
// Moore FSM that sequences the shared datapath (memory address mux, ALU
// operand muxes, PC source mux, writeback muxes, IR/PC/RF/memory write
// enables), plus the ALU decoder that produces ALUControl.
//
// Ports:
//   clk, rst     clock (rising edge) and synchronous active-high reset
//   Op, Funct    opcode and funct fields from the instruction register
//   Zero         ALU result == 0, used only while branching
//   IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
//   ALUSrcB, ALUControl, PCSrc, PCEn
//                datapath mux selects and write enables
//   illegal_op   one-cycle pulse on an undecodable opcode or funct
//   state_out    current state code, for debug
//
// Optional feature macro: MIPS_MC_BNE_EN -- when defined, bne (Op 0x05)
// branches with the inverted Zero condition; otherwise 0x05 is illegal.

module mips_mc_control #(
    parameter int unsigned OP_W      = 6,
    parameter int unsigned FUNCT_W   = 6,
    parameter int unsigned ALUCTRL_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OP_W-1:0]      Op,
    input  logic [FUNCT_W-1:0]   Funct,
    input  logic                 Zero,
    output logic                 IorD,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegDst,
    output logic                 MemtoReg,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [1:0]           PCSrc,
    output logic                 PCEn,
    output logic                 illegal_op,
    output logic [3:0]           state_out
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'h00);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'h02);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'h05);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'h08);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2B);

    localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(6'h20);
    localparam logic [FUNCT_W-1:0] FN_SUB = FUNCT_W'(6'h22);
    localparam logic [FUNCT_W-1:0] FN_AND = FUNCT_W'(6'h24);
    localparam logic [FUNCT_W-1:0] FN_OR  = FUNCT_W'(6'h25);
    localparam logic [FUNCT_W-1:0] FN_SLT = FUNCT_W'(6'h2A);

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(3'b010);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(3'b110);
    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(3'b000);
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(3'b001);
    localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(3'b111);

    state_t state_q, state_d;

    // Op is only valid in DECODE, so the lw/sw choice made in MEMADR
    // comes from a flag captured there.
    logic is_sw_q;

    logic                 op_ok;
    state_t               decode_tgt;
    logic                 funct_ok;
    logic [ALUCTRL_W-1:0] funct_ctrl;
    logic                 branch_cond;

    logic [1:0] alu_op;
    logic       alu_dec_en;
    logic       pc_write;
    logic       branch;

`ifdef MIPS_MC_BNE_EN
    logic bne_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bne_q <= 1'b0;
        end else if (state_q == S_DECODE) begin
            bne_q <= (Op == OP_BNE);
        end
    end

    assign branch_cond = bne_q ? ~Zero : Zero;
`else
    assign branch_cond = Zero;
`endif

    // Opcode decode: DECODE successor and legality.
    always_comb begin
        op_ok      = 1'b1;
        decode_tgt = S_FETCH;
        case (Op)
            OP_LW, OP_SW: decode_tgt = S_MEMADR;
            OP_RTYPE:     decode_tgt = S_EXECUTE;
            OP_BEQ:       decode_tgt = S_BRANCH;
`ifdef MIPS_MC_BNE_EN
            OP_BNE:       decode_tgt = S_BRANCH;
`endif
            OP_ADDI:      decode_tgt = S_ADDIEXEC;
            OP_J:         decode_tgt = S_JUMP;
            default:      op_ok      = 1'b0;
        endcase
    end

    // R-type funct decode; unknown funct keeps the add encoding.
    always_comb begin
        funct_ok   = 1'b1;
        funct_ctrl = ALU_ADD;
        case (Funct)
            FN_ADD:  funct_ctrl = ALU_ADD;
            FN_SUB:  funct_ctrl = ALU_SUB;
            FN_AND:  funct_ctrl = ALU_AND;
            FN_OR:   funct_ctrl = ALU_OR;
            FN_SLT:  funct_ctrl = ALU_SLT;
            default: funct_ok   = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE:   state_d = decode_tgt;
            S_MEMADR:   state_d = is_sw_q ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTE:  state_d = funct_ok ? S_ALUWB : S_FETCH;
            S_ADDIEXEC: state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                is_sw_q <= (Op == OP_SW);
            end
        end
    end

    // Moore outputs. Reset overrides last so that, whatever the state,
    // no write enable is active while rst is high.
    always_comb begin
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        illegal_op = 1'b0;
        alu_op     = 2'b00;
        alu_dec_en = 1'b1;
        pc_write   = 1'b0;
        branch     = 1'b0;

        case (state_q)
            S_FETCH: begin
                ALUSrcB  = 2'b01;
                IRWrite  = 1'b1;
                pc_write = 1'b1;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                illegal_op = ~op_ok;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMREAD: IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA    = 1'b1;
                alu_op     = 2'b10;
                illegal_op = ~funct_ok;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                alu_op  = 2'b01;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: alu_dec_en = 1'b0;
        endcase

        if (!alu_dec_en) begin
            ALUControl = '0;
        end else begin
            case (alu_op)
                2'b00:   ALUControl = ALU_ADD;
                2'b01:   ALUControl = ALU_SUB;
                default: ALUControl = funct_ctrl;
            endcase
        end

        PCEn = pc_write | (branch & branch_cond);

        if (rst) begin
            IorD       = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegDst     = 1'b0;
            MemtoReg   = 1'b0;
            RegWrite   = 1'b0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b01;
            ALUControl = ALU_ADD;
            PCSrc      = 2'b00;
            PCEn       = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign state_out = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control -- self-checking bench for mips_mc_control.
// Directed scenarios per feature followed by randomized instruction streams
// checked against an instruction-level reference model.

module tb_mips_mc_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] Op = 6'h23;
    logic [5:0] Funct = 6'h20;
    logic       Zero = 1'b0;

    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic       PCEn, illegal_op;
    logic [3:0] state_out;
    logic [15:0] obs;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_mc_control #(.OP_W(6), .FUNCT_W(6), .ALUCTRL_W(3)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc),
        .PCEn(PCEn), .illegal_op(illegal_op), .state_out(state_out)
    );

    assign obs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                  ALUSrcB, ALUControl, PCSrc, PCEn, illegal_op};

`ifdef MIPS_MC_BNE_EN
    localparam bit BNE_ON = 1'b1;
`else
    localparam bit BNE_ON = 1'b0;
`endif

    // ---------------- reference model ----------------
    function automatic int funct_alu(input logic [5:0] f);
        case (f)
            6'h20:   return 2;
            6'h22:   return 6;
            6'h24:   return 0;
            6'h25:   return 1;
            6'h2A:   return 7;
            default: return -1;
        endcase
    endfunction

    // Instruction class -> ordered list of state codes it visits.
    function automatic void build_seq(input logic [5:0] op, input logic [5:0] fn,
                                      output int seq[$]);
        seq = '{0, 1};
        case (op)
            6'h23: seq = '{0, 1, 2, 3, 4};
            6'h2B: seq = '{0, 1, 2, 5};
            6'h00: seq = (funct_alu(fn) >= 0) ? '{0, 1, 6, 7} : '{0, 1, 6};
            6'h04: seq = '{0, 1, 8};
            6'h05: if (BNE_ON) seq = '{0, 1, 8};
            6'h08: seq = '{0, 1, 9, 10};
            6'h02: seq = '{0, 1, 11};
            default: ;
        endcase
    endfunction

    function automatic bit op_known(input logic [5:0] op);
        return (op == 6'h23 || op == 6'h2B || op == 6'h00 || op == 6'h04 ||
                op == 6'h08 || op == 6'h02 || (BNE_ON && op == 6'h05));
    endfunction

    function automatic logic [15:0] model_out(input int st, input logic [5:0] op,
                                              input logic [5:0] fn, input logic z,
                                              input bit is_bne, input logic r);
        logic iord = 0, memw = 0, irw = 0, regdst = 0, m2r = 0, regw = 0;
        logic srca = 0, pcen = 0, ill = 0;
        logic [1:0] srcb = 2'b00, pcsrc = 2'b00;
        logic [2:0] ctl = 3'b010;
        int fc;
        if (r) begin
            srcb = 2'b01;
        end else begin
            case (st)
                0:  begin srcb = 2'b01; irw = 1; pcen = 1; end
                1:  begin srcb = 2'b11; ill = !op_known(op); end
                2:  begin srca = 1; srcb = 2'b10; end
                3:  iord = 1;
                4:  begin m2r = 1; regw = 1; end
                5:  begin iord = 1; memw = 1; end
                6:  begin
                        srca = 1; fc = funct_alu(fn);
                        if (fc < 0) ill = 1; else ctl = fc[2:0];
                    end
                7:  begin regdst = 1; regw = 1; end
                8:  begin srca = 1; ctl = 3'b110; pcsrc = 2'b01; pcen = is_bne ? ~z : z; end
                9:  begin srca = 1; srcb = 2'b10; end
                10: regw = 1;
                11: begin pcsrc = 2'b10; pcen = 1; end
                default: ctl = 3'b000;
            endcase
        end
        return {iord, memw, irw, regdst, m2r, regw, srca, srcb, ctl, pcsrc, pcen, ill};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [15:0] e;
        rst = 1'b1; Op = 6'h23; Funct = 6'h20; Zero = 1'b0;
        e = model_out(0, Op, Funct, Zero, 1'b0, 1'b1);
        #1; total++;
        if (obs !== e) begin
            bad++; $display("FAIL reset_pre_edge got=%h exp=%h", obs, e);
        end
        @(negedge clk); #1; total++;
        if (state_out !== 4'd0 || obs !== e) begin
            bad++; $display("FAIL reset_hold state got=%0d exp=0 out got=%h exp=%h", state_out, obs, e);
        end
        @(negedge clk); rst = 1'b0; #1; total++;
        if (state_out !== 4'd0 || IRWrite !== 1'b1 || PCEn !== 1'b1) begin
            bad++; $display("FAIL reset_release state=%0d IRWrite=%b PCEn=%b exp 0/1/1", state_out, IRWrite, PCEn);
        end
    endtask

    task automatic test_lw();
        int seq[$];
        logic [15:0] e;
        seq = '{0, 1, 2, 3, 4, 0};
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        Op = 6'h23; Funct = 6'h11; Zero = 1'b1;
        foreach (seq[k]) begin
            if (k != 0) @(negedge clk);
            #1;
            e = model_out(seq[k], Op, Funct, Zero, 1'b0, 1'b0);
            total++;
            if (state_out !== 4'(seq[k]) || obs !== e) begin
                bad++; $display("FAIL lw step%0d state got=%0d exp=%0d out got=%h exp=%h", k, state_out, seq[k], obs, e);
            end
            total++;
            if ({RegWrite, MemtoReg} !== ((seq[k] == 4) ? 2'b11 : 2'b00)) begin
                bad++; $display("FAIL lw_wb step%0d RegWrite,MemtoReg got=%b%b", k, RegWrite, MemtoReg);
            end
        end
    endtask

    task automatic test_rtype();
        int seq[$];
        logic [15:0] e;
        logic [5:0] fns [2] = '{6'h22, 6'h3F};
        for (int t = 0; t < 2; t++) begin
            seq = (t == 0) ? '{0, 1, 6, 7, 0} : '{0, 1, 6, 0};
            rst = 1'b1; @(negedge clk); rst = 1'b0;
            Op = 6'h00; Funct = fns[t]; Zero = 1'b0;
            foreach (seq[k]) begin
                if (k != 0) @(negedge clk);
                #1;
                e = model_out(seq[k], Op, Funct, Zero, 1'b0, 1'b0);
                total++;
                if (state_out !== 4'(seq[k]) || obs !== e) begin
                    bad++; $display("FAIL rtype fn=%h step%0d state got=%0d exp=%0d out got=%h exp=%h", Funct, k, state_out, seq[k], obs, e);
                end
                if (seq[k] == 6) begin
                    total++;
                    if (t == 0 && (ALUControl !== 3'b110 || illegal_op !== 1'b0)) begin
                        bad++; $display("FAIL rtype_sub ALUControl got=%b exp=110 illegal_op=%b", ALUControl, illegal_op);
                    end else if (t == 1 && illegal_op !== 1'b1) begin
                        bad++; $display("FAIL rtype_bad_funct illegal_op got=%b exp=1", illegal_op);
                    end
                end
                if (seq[k] == 7) begin
                    total++;
                    if (RegDst !== 1'b1) begin
                        bad++; $display("FAIL rtype_aluwb RegDst got=%b exp=1", RegDst);
                    end
                end
            end
        end
    endtask

    task automatic test_beq();
        int seq[$];
        logic [15:0] e;
        seq = '{0, 1, 8, 0};
        for (int t = 0; t < 2; t++) begin
            rst = 1'b1; @(negedge clk); rst = 1'b0;
            Op = 6'h04; Funct = 6'h00; Zero = (t == 0);
            foreach (seq[k]) begin
                if (k != 0) @(negedge clk);
                #1;
                e = model_out(seq[k], Op, Funct, Zero, 1'b0, 1'b0);
                total++;
                if (state_out !== 4'(seq[k]) || obs !== e) begin
                    bad++; $display("FAIL beq z=%b step%0d state got=%0d exp=%0d out got=%h exp=%h", Zero, k, state_out, seq[k], obs, e);
                end
                if (seq[k] == 8) begin
                    total++;
                    if (PCEn !== Zero || PCSrc !== 2'b01) begin
                        bad++; $display("FAIL beq_branch PCEn got=%b exp=%b PCSrc got=%b exp=01", PCEn, Zero, PCSrc);
                    end
                end
            end
        end
    endtask

    task automatic test_jump_illegal();
        int seq[$];
        logic [15:0] e;
        seq = '{0, 1, 11, 0};
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        Op = 6'h02; Funct = 6'h00; Zero = 1'b0;
        foreach (seq[k]) begin
            if (k != 0) @(negedge clk);
            #1;
            e = model_out(seq[k], Op, Funct, Zero, 1'b0, 1'b0);
            total++;
            if (state_out !== 4'(seq[k]) || obs !== e) begin
                bad++; $display("FAIL jump step%0d state got=%0d exp=%0d out got=%h exp=%h", k, state_out, seq[k], obs, e);
            end
        end
        // Illegal opcode: FETCH/DECODE two-cycle loop with a pulse each DECODE.
        Op = 6'h3F;
        for (int k = 0; k < 5; k++) begin
            if (k != 0) @(negedge clk);
            #1; total++;
            if (state_out !== 4'(k % 2) || illegal_op !== ((k % 2) == 1)) begin
                bad++; $display("FAIL illegal_loop step%0d state got=%0d exp=%0d illegal_op got=%b", k, state_out, k % 2, illegal_op);
            end
        end
    endtask

    task automatic test_reset_midinstr();
        int seq[$];
        logic [15:0] e;
        seq = '{0, 1, 2};
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        Op = 6'h2B; Funct = 6'h00; Zero = 1'b0;
        foreach (seq[k]) begin
            if (k != 0) @(negedge clk);
            #1; total++;
            if (state_out !== 4'(seq[k])) begin
                bad++; $display("FAIL sw_pre step%0d state got=%0d exp=%0d", k, state_out, seq[k]);
            end
        end
        @(negedge clk); rst = 1'b1; #1;
        e = model_out(0, Op, Funct, Zero, 1'b0, 1'b1);
        total++;
        if (state_out !== 4'd5 || MemWrite !== 1'b0 || obs !== e) begin
            bad++; $display("FAIL rst_in_memwrite state got=%0d exp=5 MemWrite=%b out got=%h exp=%h", state_out, MemWrite, obs, e);
        end
        @(negedge clk); #1; total++;
        if (state_out !== 4'd0) begin
            bad++; $display("FAIL rst_after_edge state got=%0d exp=0", state_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_bne();
        for (int t = 0; t < 2; t++) begin
            rst = 1'b1; @(negedge clk); rst = 1'b0;
            Op = 6'h05; Funct = 6'h00; Zero = (t == 1);
            #1;
            @(negedge clk); #1; total++;
`ifdef MIPS_MC_BNE_EN
            if (state_out !== 4'd1 || illegal_op !== 1'b0) begin
                bad++; $display("FAIL bne_decode state got=%0d exp=1 illegal_op=%b exp=0", state_out, illegal_op);
            end
            @(negedge clk); #1; total++;
            if (state_out !== 4'd8 || PCEn !== ~Zero || PCSrc !== 2'b01) begin
                bad++; $display("FAIL bne_branch state got=%0d exp=8 PCEn got=%b exp=%b", state_out, PCEn, ~Zero);
            end
            @(negedge clk); #1; total++;
            if (state_out !== 4'd0) begin
                bad++; $display("FAIL bne_return state got=%0d exp=0", state_out);
            end
`else
            if (state_out !== 4'd1 || illegal_op !== 1'b1) begin
                bad++; $display("FAIL bne_illegal state got=%0d exp=1 illegal_op=%b exp=1", state_out, illegal_op);
            end
            @(negedge clk); #1; total++;
            if (state_out !== 4'd0) begin
                bad++; $display("FAIL bne_illegal_return state got=%0d exp=0", state_out);
            end
`endif
        end
    endtask

    task automatic test_random();
        int seq[$];
        logic [15:0] e;
        logic [5:0] op, fn;
        logic [5:0] legal_fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        int sel;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0: op = 6'h23;
                1: op = 6'h2B;
                2: op = 6'h00;
                3: op = 6'h04;
                4: op = 6'h08;
                5: op = 6'h02;
                6: op = 6'h05;
                default: begin
                    op = 6'($urandom);
                    while (op == 6'h23 || op == 6'h2B || op == 6'h00 || op == 6'h04 ||
                           op == 6'h08 || op == 6'h02 || op == 6'h05)
                        op = 6'($urandom);
                end
            endcase
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 4)];
            build_seq(op, fn, seq);
            foreach (seq[k]) begin
                if (n != 0 || k != 0) @(negedge clk);
                // Fields are only meaningful in DECODE / EXECUTE; elsewhere drive noise.
                Op    = (seq[k] == 1) ? op : 6'($urandom);
                Funct = (seq[k] == 6) ? fn : 6'($urandom);
                Zero  = 1'($urandom);
                #1;
                e = model_out(seq[k], Op, Funct, Zero, (op == 6'h05), 1'b0);
                total++;
                if (state_out !== 4'(seq[k]) || obs !== e) begin
                    bad++; $display("FAIL random n=%0d op=%h fn=%h step%0d state got=%0d exp=%0d out got=%h exp=%h",
                                    n, op, fn, k, state_out, seq[k], obs, e);
                end
            end
        end
        @(negedge clk); #1; total++;
        if (state_out !== 4'd0) begin
            bad++; $display("FAIL random_end state got=%0d exp=0", state_out);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_beq();
        test_jump_illegal();
        test_reset_midinstr();
        test_bne();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
